// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the fifo write-port arbiter.
package fifo_arb_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_t;

   localparam int DATA_W_DEF = 8;

   // Minimum result is 1 so single-entry ranges still get a real bit.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      if (r < 1) r = 1;
      return r;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side valid/ready channels plus the fifo write port, as seen by the arbiter.
interface fifo_wr_arbiter_if
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int ID_W    = clog2(NUM_REQ)
);

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      fifo_full;
   logic                      fifo_wr_en;
   logic [DATA_W-1:0]         fifo_data_in;
   logic [ID_W-1:0]           grant_id;
   logic                      busy;

   modport slave (
      input  req_valid, req_data, fifo_full,
      output req_ready, fifo_wr_en, fifo_data_in, grant_id, busy
   );

   modport master (
      output req_valid, req_data, fifo_full,
      input  req_ready, fifo_wr_en, fifo_data_in, grant_id, busy
   );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after last_id, wrapping.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    last_id,
   output logic [ID_W-1:0]    pick_id,
   output logic               any
);

   always_comb begin
      pick_id = '0;
      any     = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         int idx;
         idx = (int'(last_id) + k) % NUM_REQ;
         if (!any && req[idx]) begin
            any     = 1'b1;
            pick_id = ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Grants the single fifo write port to one producer for up to BURST_MAX beats,
// rotating ownership round-robin and honouring fifo_full back-pressure.
//
// state    | meaning
// ST_IDLE  | no owner; one-cycle arbitration bubble, winner registered as owner
// ST_BURST | owner may write; ends on last beat or on owner valid drop
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int BURST_MAX = 4,
   localparam int ID_W     = clog2(NUM_REQ)
) (
   input  logic            clk,
   input  logic            rst,
   fifo_wr_arbiter_if.slave bus
);

   localparam int              CNT_W    = clog2(BURST_MAX);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_MAX - 1);

   state_t              state, state_nxt;
   logic [ID_W-1:0]     owner, owner_nxt;
   logic [ID_W-1:0]     last_id, last_id_nxt;
   logic [CNT_W-1:0]    beat_cnt, beat_cnt_nxt;
   logic [ID_W-1:0]     pick_id;
   logic                pick_any;
   logic                owner_valid;
   logic                xfer;
   logic                in_burst;
   logic [DATA_W-1:0]   owner_data;
   logic [NUM_REQ-1:0]  ready;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_pick (
      .req     (bus.req_valid),
      .last_id (last_id),
      .pick_id (pick_id),
      .any     (pick_any)
   );

   // Reset gates outputs in the same cycle so a burst cut by reset writes nothing.
   assign in_burst    = (state == ST_BURST) && !rst;
   assign owner_valid = bus.req_valid[owner];
   assign owner_data  = bus.req_data[int'(owner)*DATA_W +: DATA_W];
   assign xfer        = in_burst && owner_valid && !bus.fifo_full;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         owner    <= '0;
         last_id  <= ID_W'(NUM_REQ - 1);
         beat_cnt <= '0;
      end else begin
         state    <= state_nxt;
         owner    <= owner_nxt;
         last_id  <= last_id_nxt;
         beat_cnt <= beat_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      owner_nxt    = owner;
      last_id_nxt  = last_id;
      beat_cnt_nxt = beat_cnt;
      case (state)
         ST_IDLE: begin
            if (pick_any) begin
               state_nxt    = ST_BURST;
               owner_nxt    = pick_id;
               beat_cnt_nxt = '0;
            end
         end
         ST_BURST: begin
            if (xfer) begin
               if (beat_cnt == CNT_LAST) begin
                  state_nxt    = ST_IDLE;
                  last_id_nxt  = owner;
                  beat_cnt_nxt = '0;
               end else begin
                  beat_cnt_nxt = beat_cnt + 1'b1;
               end
            end else if (!owner_valid) begin
               // A stall with valid held keeps ownership; only a valid drop ends it.
               state_nxt    = ST_IDLE;
               last_id_nxt  = owner;
               beat_cnt_nxt = '0;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      ready = '0;
      if (in_burst) ready[owner] = !bus.fifo_full;
   end

   assign bus.req_ready    = ready;
   assign bus.fifo_wr_en   = xfer;
   assign bus.fifo_data_in = xfer ? owner_data : '0;
   assign bus.grant_id     = owner;
   assign bus.busy         = in_burst;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: vector table plus hand-written multi-cycle sequences.
module tb_fifo_wr_arbiter;

   logic clk;
   logic rst;

   fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_W(8), .ID_W(2)) bus ();

   fifo_wr_arbiter #(
      .NUM_REQ   (4),
      .DATA_W    (8),
      .BURST_MAX (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [3:0]  valid;
      logic [31:0] data;
      logic        full;
      logic [3:0]  e_ready;
      logic        e_wr;
      logic [7:0]  e_data;
      logic        e_busy;
      logic        chk_g;
      logic [1:0]  e_grant;
   } vec_t;

   localparam logic [31:0] ROT = 32'h23222120;

   int         total;
   int         bad;
   vec_t       vt[17];
   logic [7:0] sb[$];
   logic [7:0] exp_sb[7];

   function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [31:0] d,
                               input logic f, input logic [3:0] er, input logic ew,
                               input logic [7:0] ed, input logic eb, input logic cg,
                               input logic [1:0] eg);
      vec_t x;
      x.rst = r; x.valid = v; x.data = d; x.full = f;
      x.e_ready = er; x.e_wr = ew; x.e_data = ed; x.e_busy = eb;
      x.chk_g = cg; x.e_grant = eg;
      return x;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input logic r, input logic [3:0] v, input logic [31:0] d, input logic f);
      rst           = r;
      bus.req_valid = v;
      bus.req_data  = d;
      bus.fifo_full = f;
      @(negedge clk);
   endtask

   task automatic adv();
      if (bus.fifo_wr_en === 1'b1) sb.push_back(bus.fifo_data_in);
      @(posedge clk);
      #1;
   endtask

   initial begin
      total = 0;
      bad   = 0;

      // reset, single producer (rule b), back-pressure (rule a), non-owner valid ignored
      vt[0]  = mk(1, 4'hF, 32'hFFFF_FFFF, 0, 4'h0, 0, 8'h00, 0, 0, 2'd0);
      vt[1]  = mk(1, 4'hF, 32'hFFFF_FFFF, 0, 4'h0, 0, 8'h00, 0, 1, 2'd0);
      vt[2]  = mk(0, 4'h1, 32'h0000_0004, 0, 4'h0, 0, 8'h00, 0, 1, 2'd0);
      vt[3]  = mk(0, 4'h1, 32'h0000_0004, 0, 4'h1, 1, 8'h04, 1, 1, 2'd0);
      vt[4]  = mk(0, 4'h1, 32'h0000_0005, 0, 4'h1, 1, 8'h05, 1, 1, 2'd0);
      vt[5]  = mk(0, 4'h1, 32'h0000_0006, 0, 4'h1, 1, 8'h06, 1, 1, 2'd0);
      vt[6]  = mk(0, 4'h0, 32'h0000_0000, 0, 4'h1, 0, 8'h00, 1, 1, 2'd0);
      vt[7]  = mk(0, 4'h0, 32'h0000_0000, 0, 4'h0, 0, 8'h00, 0, 1, 2'd0);
      vt[8]  = mk(0, 4'h2, 32'h0000_1000, 0, 4'h0, 0, 8'h00, 0, 1, 2'd0);
      vt[9]  = mk(0, 4'h2, 32'h0000_1000, 0, 4'h2, 1, 8'h10, 1, 1, 2'd1);
      vt[10] = mk(0, 4'hA, 32'h9900_1100, 0, 4'h2, 1, 8'h11, 1, 1, 2'd1);
      vt[11] = mk(0, 4'h2, 32'h0000_1200, 1, 4'h0, 0, 8'h00, 1, 1, 2'd1);
      vt[12] = mk(0, 4'h2, 32'h0000_1200, 1, 4'h0, 0, 8'h00, 1, 1, 2'd1);
      vt[13] = mk(0, 4'h2, 32'h0000_1200, 1, 4'h0, 0, 8'h00, 1, 1, 2'd1);
      vt[14] = mk(0, 4'h2, 32'h0000_1200, 0, 4'h2, 1, 8'h12, 1, 1, 2'd1);
      vt[15] = mk(0, 4'h2, 32'h0000_1300, 0, 4'h2, 1, 8'h13, 1, 1, 2'd1);
      vt[16] = mk(0, 4'h0, 32'h0000_0000, 0, 4'h0, 0, 8'h00, 0, 1, 2'd1);

      exp_sb[0] = 8'h04; exp_sb[1] = 8'h05; exp_sb[2] = 8'h06;
      exp_sb[3] = 8'h10; exp_sb[4] = 8'h11; exp_sb[5] = 8'h12; exp_sb[6] = 8'h13;

      for (int i = 0; i < 17; i++) begin
         cyc(vt[i].rst, vt[i].valid, vt[i].data, vt[i].full);
         chk($sformatf("vec%0d_ready", i), 32'(bus.req_ready),    32'(vt[i].e_ready));
         chk($sformatf("vec%0d_wr_en", i), 32'(bus.fifo_wr_en),   32'(vt[i].e_wr));
         chk($sformatf("vec%0d_data", i),  32'(bus.fifo_data_in), 32'(vt[i].e_data));
         chk($sformatf("vec%0d_busy", i),  32'(bus.busy),         32'(vt[i].e_busy));
         if (vt[i].chk_g) chk($sformatf("vec%0d_grant", i), 32'(bus.grant_id), 32'(vt[i].e_grant));
         adv();
      end

      chk("sb_count", 32'(sb.size()), 32'd7);
      for (int i = 0; i < 7; i++) begin
         if (i < sb.size()) chk($sformatf("sb_beat%0d", i), 32'(sb[i]), 32'(exp_sb[i]));
      end

      // rotation: fresh reset, all four valid, expect owners 0,1,2,3,0 with 4 beats each
      cyc(1, 4'hF, ROT, 0); adv();
      cyc(1, 4'hF, ROT, 0); adv();
      for (int b = 0; b < 5; b++) begin
         int id;
         id = b % 4;
         cyc(0, 4'hF, ROT, 0);
         chk($sformatf("rot%0d_bubble_busy", b), 32'(bus.busy), 32'd0);
         chk($sformatf("rot%0d_bubble_wr", b), 32'(bus.fifo_wr_en), 32'd0);
         adv();
         for (int k = 0; k < 4; k++) begin
            cyc(0, 4'hF, ROT, 0);
            chk($sformatf("rot%0d_%0d_grant", b, k), 32'(bus.grant_id), 32'(id));
            chk($sformatf("rot%0d_%0d_wr", b, k), 32'(bus.fifo_wr_en), 32'd1);
            chk($sformatf("rot%0d_%0d_data", b, k), 32'(bus.fifo_data_in), 32'h20 + 32'(id));
            chk($sformatf("rot%0d_%0d_ready", b, k), 32'(bus.req_ready), 32'(1) << id);
            adv();
         end
      end

      // early end: last owner 0, producers 0,2,3 valid -> owner 2, drops after one beat
      cyc(0, 4'b1101, ROT, 0);
      chk("early_bubble_busy", 32'(bus.busy), 32'd0);
      adv();
      cyc(0, 4'b1101, ROT, 0);
      chk("early_o2_grant", 32'(bus.grant_id), 32'd2);
      chk("early_o2_data", 32'(bus.fifo_data_in), 32'h22);
      adv();
      cyc(0, 4'b1001, ROT, 0);
      chk("early_drop_wr", 32'(bus.fifo_wr_en), 32'd0);
      chk("early_drop_ready", 32'(bus.req_ready), 32'b0100);
      adv();
      cyc(0, 4'b1001, ROT, 0);
      chk("early_idle_busy", 32'(bus.busy), 32'd0);
      adv();
      for (int k = 0; k < 4; k++) begin
         cyc(0, 4'b1001, ROT, 0);
         chk($sformatf("early_o3_%0d_grant", k), 32'(bus.grant_id), 32'd3);
         chk($sformatf("early_o3_%0d_data", k), 32'(bus.fifo_data_in), 32'h23);
         adv();
      end
      cyc(0, 4'b1001, ROT, 0);
      chk("early_idle2_busy", 32'(bus.busy), 32'd0);
      adv();
      cyc(0, 4'b1001, ROT, 0);
      chk("early_o0_grant", 32'(bus.grant_id), 32'd0);
      chk("early_o0_wr", 32'(bus.fifo_wr_en), 32'd1);
      adv();
      cyc(0, 4'b0000, ROT, 0); adv();

      // reset mid-burst of owner 1, then producer 0 wins first
      cyc(1, 4'h0, ROT, 0); adv();
      cyc(1, 4'h0, ROT, 0); adv();
      cyc(0, 4'b0010, ROT, 0); adv();
      cyc(0, 4'b0010, ROT, 0);
      chk("rstmid_beat1_grant", 32'(bus.grant_id), 32'd1);
      chk("rstmid_beat1_wr", 32'(bus.fifo_wr_en), 32'd1);
      adv();
      cyc(1, 4'b0010, ROT, 0);
      chk("rstmid_wr", 32'(bus.fifo_wr_en), 32'd0);
      chk("rstmid_ready", 32'(bus.req_ready), 32'd0);
      chk("rstmid_data", 32'(bus.fifo_data_in), 32'd0);
      chk("rstmid_busy", 32'(bus.busy), 32'd0);
      adv();
      cyc(0, 4'b0011, ROT, 0);
      chk("rstmid_idle_busy", 32'(bus.busy), 32'd0);
      adv();
      cyc(0, 4'b0011, ROT, 0);
      chk("rstmid_next_grant", 32'(bus.grant_id), 32'd0);
      chk("rstmid_next_data", 32'(bus.fifo_data_in), 32'h20);
      chk("rstmid_next_ready", 32'(bus.req_ready), 32'b0001);
      adv();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
